// File: rtl/bc_input_port.sv
// rtl/bc_input_port.sv - 8N1 serial receiver feeding the Basic Computer INPR/FGI input path
module bc_input_port #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  input  logic       clrFGI,
  output logic [7:0] INPR,
  output logic       FGI,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      bidx, bidx_nxt;
  logic [7:0]      shreg, shreg_nxt;
  logic            sync1, rx_s;
  logic            byte_ok, ferr_set;

  // rxd is asynchronous; only the second flop output is ever looked at
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rxd;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      bidx  <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      bidx  <= bidx_nxt;
      shreg <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bidx_nxt  = bidx;
    shreg_nxt = shreg;
    byte_ok   = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_nxt = '0;
          if (!rx_s) begin
            state_nxt = DATA;
            bidx_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_nxt   = '0;
          shreg_nxt = {rx_s, shreg[7:1]};
          if (bidx == 3'd7) state_nxt = STOP;
          else              bidx_nxt  = bidx + 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_nxt = '0;
          if (rx_s) begin
            byte_ok   = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        // a break line yields one frame error, not a stream of zero frames
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // flag set events win over a coincident clrFGI
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      INPR      <= 8'h00;
      FGI       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (byte_ok && (!FGI || clrFGI)) begin
        INPR <= shreg;
        FGI  <= 1'b1;
      end else if (clrFGI) begin
        FGI  <= 1'b0;
      end

      if (ferr_set)    frame_err <= 1'b1;
      else if (clrFGI) frame_err <= 1'b0;

      if (byte_ok && FGI && !clrFGI) overrun <= 1'b1;
      else if (clrFGI)               overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bc_input_port.sv
// tb/tb_bc_input_port.sv - randomized self-checking bench for bc_input_port against a frame-level model
module tb_bc_input_port;

  localparam int CPB = 16;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd = 1'b1;
  logic       clrFGI = 1'b0;
  logic [7:0] INPR;
  logic       FGI, frame_err, overrun;

  int n_vec = 0;
  int n_err = 0;
  int rise_at;

  logic [7:0] m_inpr;
  logic       m_fgi, m_fe, m_ov;

  bc_input_port #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset_n(reset_n), .rxd(rxd), .clrFGI(clrFGI),
    .INPR(INPR), .FGI(FGI), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_inpr = 8'h00; m_fgi = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
  endtask

  // frame-level view: one event at the stop sample, clr on that edge loses to set
  task automatic model_frame(input logic [7:0] d, input logic stop, input logic clr);
    if (stop) begin
      if (!m_fgi || clr) begin
        m_inpr = d; m_fgi = 1'b1;
        if (clr) m_ov = 1'b0;
      end else begin
        m_ov = 1'b1;
      end
      if (clr) m_fe = 1'b0;
    end else begin
      m_fe = 1'b1;
      if (clr) begin m_fgi = 1'b0; m_ov = 1'b0; end
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int clr_at);
    logic [9:0] fr;
    logic       prev;
    fr = {stop, d, 1'b0};
    rise_at = -1;
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge clk);
      rxd = fr[c / CPB];
      clrFGI = (c == clr_at);
      prev = FGI;
      @(posedge clk); #1;
      if (rise_at < 0 && !prev && FGI) rise_at = c;
    end
    clrFGI = 1'b0;
    model_frame(d, stop, clr_at == LAT);
  endtask

  task automatic idle(input int n, input logic lvl);
    repeat (n) begin
      @(negedge clk);
      rxd = lvl;
      clrFGI = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk); rxd = 1'b1; clrFGI = 1'b1;
    @(negedge clk); clrFGI = 1'b0;
    m_fgi = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rxd = 1'b1; clrFGI = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({INPR, FGI, frame_err, overrun} !== 11'h000) begin
      n_err++;
      $display("FAIL reset: got INPR=%h FGI=%b fe=%b ov=%b, want all zero", INPR, FGI, frame_err, overrun);
    end
    reset_n = 1'b1;
    idle(5, 1'b1);
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1, -1);
    n_vec++;
    if (rise_at !== LAT) begin
      n_err++;
      $display("FAIL latency: FGI rose at edge %0d, want %0d", rise_at, LAT);
    end
    n_vec++;
    if ({INPR, FGI, frame_err, overrun} !== {8'hA5, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL basic_a5: got %h/%b/%b/%b, want a5/1/0/0", INPR, FGI, frame_err, overrun);
    end
  endtask

  task automatic test_overrun();
    send_frame(8'h3C, 1'b1, -1);
    n_vec++;
    if ({INPR, FGI, frame_err, overrun} !== {m_inpr, m_fgi, m_fe, m_ov} || !overrun) begin
      n_err++;
      $display("FAIL overrun_set: got %h/%b/%b/%b, want %h/%b/%b/%b", INPR, FGI, frame_err, overrun, m_inpr, m_fgi, m_fe, m_ov);
    end
    pulse_clr();
    n_vec++;
    if ({INPR, FGI, frame_err, overrun} !== {8'hA5, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL overrun_clr: got %h/%b/%b/%b, want a5/0/0/0", INPR, FGI, frame_err, overrun);
    end
  endtask

  task automatic test_clr_same_edge();
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    send_frame(8'h81, 1'b1, LAT);
    n_vec++;
    if ({INPR, FGI, frame_err, overrun} !== {8'h81, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL clr_same_edge: got %h/%b/%b/%b, want 81/1/0/0", INPR, FGI, frame_err, overrun);
    end
  endtask

  task automatic test_glitch();
    idle(5, 1'b1);
    idle(4, 1'b0);
    idle(3 * CPB, 1'b1);
    n_vec++;
    if ({INPR, FGI, frame_err, overrun} !== {m_inpr, m_fgi, m_fe, m_ov}) begin
      n_err++;
      $display("FAIL glitch: got %h/%b/%b/%b, want %h/%b/%b/%b", INPR, FGI, frame_err, overrun, m_inpr, m_fgi, m_fe, m_ov);
    end
  endtask

  task automatic test_break();
    pulse_clr();
    send_frame(8'h55, 1'b0, -1);
    idle(40, 1'b0);
    n_vec++;
    if ({INPR, FGI, frame_err, overrun} !== {m_inpr, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL break: got %h/%b/%b/%b, want %h/0/1/0", INPR, FGI, frame_err, overrun, m_inpr);
    end
    idle(4, 1'b1);
    send_frame(8'h01, 1'b1, -1);
    n_vec++;
    if ({INPR, FGI, frame_err, overrun} !== {8'h01, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL after_break: got %h/%b/%b/%b, want 01/1/1/0", INPR, FGI, frame_err, overrun);
    end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] fr;
    fr = {1'b1, 8'hF0, 1'b0};
    for (int c = 0; c < 5 * CPB + CPB / 2; c++) begin
      @(negedge clk);
      rxd = fr[c / CPB];
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if ({INPR, FGI, frame_err, overrun} !== 11'h000) begin
      n_err++;
      $display("FAIL midframe_reset: got %h/%b/%b/%b, want 00/0/0/0", INPR, FGI, frame_err, overrun);
    end
    idle(3, 1'b1);
    reset_n = 1'b1;
    idle(5, 1'b1);
    send_frame(8'h0F, 1'b1, -1);
    n_vec++;
    if ({INPR, FGI, frame_err, overrun} !== {8'h0F, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL after_reset_0f: got %h/%b/%b/%b, want 0f/1/0/0", INPR, FGI, frame_err, overrun);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       stop;
    int         mode;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      mode = $urandom_range(0, 3);
      if (mode == 0) pulse_clr();
      send_frame(d, stop, (mode == 1) ? LAT : -1);
      n_vec++;
      if ({INPR, FGI, frame_err, overrun} !== {m_inpr, m_fgi, m_fe, m_ov}) begin
        n_err++;
        $display("FAIL random[%0d] d=%h stop=%b mode=%0d: got %h/%b/%b/%b, want %h/%b/%b/%b",
                 i, d, stop, mode, INPR, FGI, frame_err, overrun, m_inpr, m_fgi, m_fe, m_ov);
      end
      if (!stop) idle(4 + $urandom_range(0, 8), 1'b1);
      else if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 20), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_clr_same_edge();
    test_glitch();
    test_break();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
